// File: rtl/onehot_mux_pipe.sv
// onehot_mux_pipe: registered one-hot N-way selector with valid/ready output and rejected-select counter (option: ONEHOT_MUX_PRIORITY_EN)
module onehot_mux_pipe #(
   parameter int N         = 16,
   parameter int WIDTH     = 32,
   parameter int ERR_CNT_W = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [N*WIDTH-1:0]   mux_in,
   input  logic [N-1:0]         hotselect,
   input  logic                 sel_valid,
   output logic                 sel_ready,
   output logic [WIDTH-1:0]     muxout,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic                 sel_error,
   output logic [ERR_CNT_W-1:0] err_count
);
   localparam logic [N-1:0]         ONE     = {{(N-1){1'b0}}, 1'b1};
   localparam logic [ERR_CNT_W-1:0] CNT_ONE = {{(ERR_CNT_W-1){1'b0}}, 1'b1};
   localparam logic [ERR_CNT_W-1:0] CNT_MAX = '1;
   typedef enum logic {EMPTY, FULL} state_t;
   state_t           state, state_n;
   logic [N-1:0]     low;
   logic [WIDTH-1:0] sel_data;
   logic             legal, accept, load;
   // lowest set bit; equals hotselect whenever the select is truly one-hot
   assign low = hotselect & (~hotselect + ONE);
`ifdef ONEHOT_MUX_PRIORITY_EN
   assign legal = |hotselect;
`else
   assign legal = |hotselect && ((hotselect & (hotselect - ONE)) == '0);
`endif
   assign out_valid = (state == FULL);
   assign sel_ready = !reset && (!out_valid || out_ready);
   assign accept    = sel_valid && sel_ready;
   assign load      = accept && legal;
   // AND-OR selection of the channel picked by the lowest set select bit
   always_comb begin
      sel_data = '0;
      for (int k = 0; k < N; k++)
         sel_data = sel_data | (mux_in[k*WIDTH +: WIDTH] & {WIDTH{low[k]}});
   end
   // output FSM next state: fill on legal accept, drain on consume without refill
   always_comb begin
      state_n = state;
      if (state == EMPTY)
         state_n = load ? FULL : EMPTY;
      else
         state_n = (out_ready && !load) ? EMPTY : FULL;
   end
   // output FSM state register
   always_ff @(posedge clk) begin
      if (reset) state <= EMPTY;
      else       state <= state_n;
   end
   // data register, one-cycle error pulse and saturating error counter
   always_ff @(posedge clk) begin
      if (reset) begin
         muxout    <= '0;
         sel_error <= 1'b0;
         err_count <= '0;
      end else begin
         if (load) muxout <= sel_data;
         sel_error <= accept && !legal;
         if (accept && !legal && err_count != CNT_MAX) err_count <= err_count + CNT_ONE;
      end
   end
endmodule

// File: tb/tb_onehot_mux_pipe.sv
// tb_onehot_mux_pipe: randomized scoreboard bench for onehot_mux_pipe against a queue-based reference model
module tb_onehot_mux_pipe;
   localparam int N = 16;
   localparam int W = 32;
   localparam int E = 8;
   logic           clk = 1'b0;
   logic           reset;
   logic [N*W-1:0] mux_in;
   logic [N-1:0]   hotselect;
   logic           sel_valid, sel_ready, out_valid, out_ready, sel_error;
   logic [W-1:0]   muxout;
   logic [E-1:0]   err_count;
   logic [W-1:0]   ch [N];
   logic [W-1:0]   exp_q [$];
   logic [W-1:0]   exp_last = '0;
   logic [E-1:0]   exp_cnt = '0;
   logic           exp_err = 1'b0;
   int             passed = 0;
   int             total = 0;

   onehot_mux_pipe #(.N(N), .WIDTH(W), .ERR_CNT_W(E)) dut (
      .clk(clk), .reset(reset), .mux_in(mux_in), .hotselect(hotselect),
      .sel_valid(sel_valid), .sel_ready(sel_ready), .muxout(muxout),
      .out_valid(out_valid), .out_ready(out_ready), .sel_error(sel_error),
      .err_count(err_count)
   );

   always #5 clk = ~clk;

   always_comb begin
      mux_in = '0;
      for (int k = 0; k < N; k++) mux_in[k*W +: W] = ch[k];
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // reference model: predicts each edge from the stable inputs, queueing accepted words
   always @(negedge clk) begin : model
      int idx;
      logic lg, rdy, acc;
      rdy = !reset && (exp_q.size() == 0 || out_ready);
      chk("sel_ready", {63'd0, sel_ready}, {63'd0, rdy});
      if (reset) begin
         exp_q.delete();
         exp_last = '0;
         exp_cnt  = '0;
         exp_err  = 1'b0;
      end else begin
         idx = -1;
         for (int k = N - 1; k >= 0; k--) if (hotselect[k]) idx = k;
`ifdef ONEHOT_MUX_PRIORITY_EN
         lg = (hotselect != 0);
`else
         lg = ($countones(hotselect) == 1);
`endif
         acc = sel_valid && rdy;
         if (out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
         if (acc && lg) begin
            exp_q.push_back(ch[idx]);
            exp_last = ch[idx];
         end
         exp_err = acc && !lg;
         if (exp_err && exp_cnt != 8'hFF) exp_cnt = exp_cnt + 8'd1;
      end
   end

   // monitor: compares the registered outputs just after each edge
   always @(posedge clk) begin
      #1;
      chk("out_valid", {63'd0, out_valid}, {63'd0, exp_q.size() != 0});
      chk("muxout", {32'd0, muxout}, {32'd0, exp_last});
      if (out_valid && exp_q.size() != 0) chk("head", {32'd0, muxout}, {32'd0, exp_q[0]});
      chk("sel_error", {63'd0, sel_error}, {63'd0, exp_err});
      chk("err_count", {56'd0, err_count}, {56'd0, exp_cnt});
   end

   task automatic drive(input logic v, input logic [N-1:0] s, input logic r);
      sel_valid = v;
      hotselect = s;
      out_ready = r;
      @(posedge clk);
      #3;
   endtask

   initial begin
      logic [N-1:0] s;
      reset = 1'b1;
      sel_valid = 1'b0;
      hotselect = '0;
      out_ready = 1'b0;
      for (int k = 0; k < N; k++) ch[k] = 32'h1000_0000 + k;
      repeat (2) begin
         @(posedge clk);
         #3;
      end
      reset = 1'b0;
      drive(1'b1, 16'h0001, 1'b1);
      chk("first_data", {32'd0, muxout}, 64'h1000_0000);
      chk("first_valid", {63'd0, out_valid}, 64'd1);
      chk("first_err", {63'd0, sel_error}, 64'd0);
      for (int k = 0; k < N; k++) begin
         drive(1'b1, 16'h0001 << k, 1'b1);
         chk("sweep_data", {32'd0, muxout}, 64'h1000_0000 + k);
         chk("sweep_valid", {63'd0, out_valid}, 64'd1);
      end
      drive(1'b1, 16'h0020, 1'b1);
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 16'h0200, 1'b0);
         chk("bp_ready", {63'd0, sel_ready}, 64'd0);
         chk("bp_hold", {32'd0, muxout}, 64'h1000_0005);
      end
      drive(1'b1, 16'h0200, 1'b1);
      chk("bp_next", {32'd0, muxout}, 64'h1000_0009);
      drive(1'b1, 16'h0000, 1'b1);
      chk("ill_zero_err", {63'd0, sel_error}, 64'd1);
      chk("ill_zero_data", {32'd0, muxout}, 64'h1000_0009);
      chk("ill_zero_valid", {63'd0, out_valid}, 64'd0);
      drive(1'b1, 16'h0003, 1'b1);
`ifdef ONEHOT_MUX_PRIORITY_EN
      chk("multi_data", {32'd0, muxout}, 64'h1000_0000);
      chk("multi_cnt", {56'd0, err_count}, 64'd1);
`else
      chk("multi_err", {63'd0, sel_error}, 64'd1);
      chk("multi_data", {32'd0, muxout}, 64'h1000_0009);
      chk("multi_cnt", {56'd0, err_count}, 64'd2);
`endif
      drive(1'b0, 16'h0000, 1'b1);
      chk("err_clear", {63'd0, sel_error}, 64'd0);
      repeat (300) drive(1'b1, 16'h0000, 1'b1);
      chk("sat_cnt", {56'd0, err_count}, 64'hFF);
      reset = 1'b1;
      drive(1'b0, 16'h0000, 1'b0);
      reset = 1'b0;
      chk("sat_reset", {56'd0, err_count}, 64'd0);
      drive(1'b1, 16'h0010, 1'b0);
      chk("mid_valid", {63'd0, out_valid}, 64'd1);
      reset = 1'b1;
      drive(1'b1, 16'h0001, 1'b0);
      reset = 1'b0;
      chk("mid_rst_valid", {63'd0, out_valid}, 64'd0);
      chk("mid_rst_data", {32'd0, muxout}, 64'd0);
      chk("mid_rst_cnt", {56'd0, err_count}, 64'd0);
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 3) == 0) ch[$urandom_range(0, N - 1)] = $urandom;
         case ($urandom_range(0, 9))
            0:       s = '0;
            1, 2:    s = N'($urandom);
            default: s = 16'h0001 << $urandom_range(0, N - 1);
         endcase
         reset = ($urandom_range(0, 199) == 0);
         drive($urandom_range(0, 3) != 0, s, $urandom_range(0, 2) != 0);
      end
      reset = 1'b0;
      drive(1'b0, 16'h0000, 1'b1);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
